pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 30 +++
 rtl/div_timer.sv | 27 ++
 rtl/pipe_stall_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Stage vectors are indexed with STG_* (bit 0 = fetch ... bit 4 = writeback).
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        DIV_WAIT   = 2'd1,
        FLUSH_HOLD = 2'd2
    } ctrlState_t;

    localparam int DIV_CYCLES = 34;
    localparam int DIV_CNT_W  = 6;
    localparam logic [DIV_CNT_W-1:0] DIV_LOAD_VAL = DIV_CNT_W'(DIV_CYCLES - 1);

    localparam int NUM_STAGES = 5;
    localparam int STG_F = 0;
    localparam int STG_D = 1;
    localparam int STG_E = 2;
    localparam int STG_M = 3;
    localparam int STG_W = 4;

    typedef logic [NUM_STAGES-1:0] stageVec_t;

    localparam stageVec_t ALL_STAGES = '1;

    function automatic stageVec_t stageBit(input int idx);
        return stageVec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/div_timer.sv
// Divider hold down-counter: load, decrement-to-zero, zero flag.
module div_timer
    import pipe_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DIV_CNT_W-1:0] loadVal,
    input  logic                 dec,
    output logic                 zero
);

    logic [DIV_CNT_W-1:0] cntReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cntReg <= '0;
        end else if (load) begin
            cntReg <= loadVal;
        end else if (dec && (cntReg != '0)) begin
            cntReg <= cntReg - 1'b1;
        end
    end

    assign zero = (cntReg == '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush with fixed event priority.
// Optional stall-cycle counter enabled by PIPE_STALL_PERF_EN.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        d_stall,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [4:0]  rtE,
    input  logic        mem_read_enE,
    input  logic        div_startE,
    input  logic        mispredE,
    input  logic        exceptM,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        stallW,
    output logic        flushF,
    output logic        flushD,
    output logic        flushE,
    output logic        flushM,
    output logic        flushW,
    output logic        div_busy,
    output logic [31:0] stall_cnt
);

    ctrlState_t stateReg;
    ctrlState_t stateNext;
    logic       divBusyReg;

    stageVec_t  stallRaw;
    stageVec_t  flushRaw;
    stageVec_t  stallVec;
    stageVec_t  flushVec;

    logic                 timerLoad;
    logic [DIV_CNT_W-1:0] timerLoadVal;
    logic                 timerDec;
    logic                 divZero;

    logic memStall;
    logic loadUse;

    assign memStall = i_stall | d_stall;
    assign loadUse  = mem_read_enE && (rtE != 5'd0) && ((rtE == rsD) || (rtE == rtD));

    div_timer u_div_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timerLoad),
        .loadVal (timerLoadVal),
        .dec     (timerDec),
        .zero    (divZero)
    );

    always_comb begin
        stallRaw     = '0;
        flushRaw     = '0;
        stateNext    = stateReg;
        timerLoad    = 1'b0;
        timerLoadVal = '0;
        timerDec     = 1'b0;

        case (stateReg)
            FLUSH_HOLD: begin
                if (memStall) begin
                    stallRaw = ALL_STAGES;
                end else begin
                    flushRaw  = ALL_STAGES;
                    stateNext = RUN;
                end
            end
            default: begin
                if (exceptM) begin
                    // Exception aborts any divide in flight.
                    timerLoad = 1'b1;
                    if (memStall) begin
                        stallRaw  = ALL_STAGES;
                        stateNext = FLUSH_HOLD;
                    end else begin
                        flushRaw  = ALL_STAGES;
                        stateNext = RUN;
                    end
                end else begin
                    // The divider keeps counting underneath a memory stall.
                    if (stateReg == DIV_WAIT) begin
                        if (divZero) begin
                            stateNext = RUN;
                        end else begin
                            timerDec = 1'b1;
                        end
                    end

                    if (memStall) begin
                        stallRaw = ALL_STAGES;
                    end else if ((stateReg == DIV_WAIT) && !divZero) begin
                        stallRaw = stageBit(STG_F) | stageBit(STG_D) | stageBit(STG_E);
                        flushRaw = stageBit(STG_M);
                    end else if ((stateReg == RUN) && div_startE) begin
                        stallRaw     = stageBit(STG_F) | stageBit(STG_D) | stageBit(STG_E);
                        flushRaw     = stageBit(STG_M);
                        timerLoad    = 1'b1;
                        timerLoadVal = DIV_LOAD_VAL;
                        stateNext    = DIV_WAIT;
                    end else if (loadUse) begin
                        stallRaw = stageBit(STG_F) | stageBit(STG_D);
                        flushRaw = stageBit(STG_E);
                    end else if (mispredE && !stallRaw[STG_E]) begin
                        flushRaw = stageBit(STG_D);
                    end
                end
            end
        endcase
    end

    // Reset blanks everything; a flush always overrides a stall on the same stage.
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            assign flushVec[gi] = !rst && flushRaw[gi];
            assign stallVec[gi] = !rst && stallRaw[gi] && !flushRaw[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg   <= RUN;
            divBusyReg <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            divBusyReg <= (stateNext == DIV_WAIT);
        end
    end

    assign stallF = stallVec[STG_F];
    assign stallD = stallVec[STG_D];
    assign stallE = stallVec[STG_E];
    assign stallM = stallVec[STG_M];
    assign stallW = stallVec[STG_W];
    assign flushF = flushVec[STG_F];
    assign flushD = flushVec[STG_D];
    assign flushE = flushVec[STG_E];
    assign flushM = flushVec[STG_M];
    assign flushW = flushVec[STG_W];

    assign div_busy = divBusyReg;

`ifdef PIPE_STALL_PERF_EN
    logic [31:0] stallCntReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCntReg <= '0;
        end else if (stallVec[STG_F] && (stallCntReg != 32'hFFFF_FFFF)) begin
            stallCntReg <= stallCntReg + 32'd1;
        end
    end

    assign stall_cnt = stallCntReg;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; stage vectors shown as {W,M,E,D,F}.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_stall = 1'b0;
    logic        d_stall = 1'b0;
    logic [4:0]  rsD = 5'd0;
    logic [4:0]  rtD = 5'd0;
    logic [4:0]  rtE = 5'd0;
    logic        mem_read_enE = 1'b0;
    logic        div_startE = 1'b0;
    logic        mispredE = 1'b0;
    logic        exceptM = 1'b0;

    logic        stallF, stallD, stallE, stallM, stallW;
    logic        flushF, flushD, flushE, flushM, flushW;
    logic        div_busy;
    logic [31:0] stall_cnt;

    logic [4:0]  stallV;
    logic [4:0]  flushV;
    assign stallV = {stallW, stallM, stallE, stallD, stallF};
    assign flushV = {flushW, flushM, flushE, flushD, flushF};

    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_ALL  = 5'b11111;
    localparam logic [4:0] S_FDE  = 5'b00111;
    localparam logic [4:0] S_FD   = 5'b00011;
    localparam logic [4:0] S_M    = 5'b01000;
    localparam logic [4:0] S_E    = 5'b00100;
    localparam logic [4:0] S_D    = 5'b00010;

`ifdef PIPE_STALL_PERF_EN
    localparam logic [31:0] EXP_PERF = 32'd36;
`else
    localparam logic [31:0] EXP_PERF = 32'd0;
`endif

    int checks = 0;
    int errors = 0;

    pipe_stall_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i_stall      (i_stall),
        .d_stall      (d_stall),
        .rsD          (rsD),
        .rtD          (rtD),
        .rtE          (rtE),
        .mem_read_enE (mem_read_enE),
        .div_startE   (div_startE),
        .mispredE     (mispredE),
        .exceptM      (exceptM),
        .stallF       (stallF),
        .stallD       (stallD),
        .stallE       (stallE),
        .stallM       (stallM),
        .stallW       (stallW),
        .flushF       (flushF),
        .flushD       (flushD),
        .flushE       (flushE),
        .flushM       (flushM),
        .flushW       (flushW),
        .div_busy     (div_busy),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_stall = 1'b0; d_stall = 1'b0; mem_read_enE = 1'b0; div_startE = 1'b0;
        mispredE = 1'b0; exceptM = 1'b0; rsD = 5'd0; rtD = 5'd0; rtE = 5'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_stall = 1'b1; d_stall = 1'b1; exceptM = 1'b1; div_startE = 1'b1;
        mispredE = 1'b1; mem_read_enE = 1'b1; rtE = 5'd5; rsD = 5'd5;
        @(negedge clk);
        $display("[tb] reset inputs-all-high stall=%b flush=%b", stallV, flushV);
        checks++; if (stallV !== S_NONE) begin errors++; $display("FAIL reset_stall: got %b want %b", stallV, S_NONE); end
        checks++; if (flushV !== S_NONE) begin errors++; $display("FAIL reset_flush: got %b want %b", flushV, S_NONE); end
        step();
        idle();
        @(negedge clk);
        checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", div_busy); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
        rst = 1'b0;
        @(negedge clk);
        $display("[tb] post-reset idle stall=%b flush=%b busy=%b", stallV, flushV, div_busy);
        checks++; if (stallV !== S_NONE || flushV !== S_NONE) begin errors++; $display("FAIL idle_out: got %b/%b want 00000/00000", stallV, flushV); end
        step();
    endtask

    task automatic test_divide();
        logic [4:0] expS;
        logic [4:0] expF;
        idle();
        div_startE = 1'b1;
        @(negedge clk);
        $display("[tb] div start stall=%b flush=%b busy=%b", stallV, flushV, div_busy);
        checks++; if (stallV !== S_FDE) begin errors++; $display("FAIL div_start_stall: got %b want %b", stallV, S_FDE); end
        checks++; if (flushV !== S_M) begin errors++; $display("FAIL div_start_flush: got %b want %b", flushV, S_M); end
        checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL div_start_busy: got %b want 0", div_busy); end
        step();
        div_startE = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            i_stall = (k == 5);
            expS = (k == 5) ? S_ALL : S_FDE;
            expF = (k == 5) ? S_NONE : S_M;
            @(negedge clk);
            $display("[tb] div t+%0d stall=%b flush=%b busy=%b", k, stallV, flushV, div_busy);
            checks++;
            if (stallV !== expS || flushV !== expF || div_busy !== 1'b1) begin
                errors++;
                $display("FAIL div_hold t+%0d: got %b/%b busy=%b want %b/%b busy=1", k, stallV, flushV, div_busy, expS, expF);
            end
            step();
        end
        i_stall = 1'b0;
        div_startE = 1'b1;
        @(negedge clk);
        $display("[tb] div t+34 stall=%b flush=%b busy=%b", stallV, flushV, div_busy);
        checks++; if (stallV !== S_NONE || flushV !== S_NONE) begin errors++; $display("FAIL div_release: got %b/%b want 00000/00000", stallV, flushV); end
        checks++; if (div_busy !== 1'b1) begin errors++; $display("FAIL div_release_busy: got %b want 1", div_busy); end
        step();
        div_startE = 1'b0;
        @(negedge clk);
        checks++; if (div_busy !== 1'b0 || stallV !== S_NONE) begin errors++; $display("FAIL div_done: busy=%b stall=%b want 0/00000", div_busy, stallV); end
        step();
    endtask

    task automatic test_load_use();
        idle();
        mem_read_enE = 1'b1; rtE = 5'd5; rsD = 5'd5; rtD = 5'd9;
        @(negedge clk);
        $display("[tb] load-use rtE=5 rsD=5 stall=%b flush=%b", stallV, flushV);
        checks++; if (stallV !== S_FD || flushV !== S_E) begin errors++; $display("FAIL lu_rs: got %b/%b want %b/%b", stallV, flushV, S_FD, S_E); end
        step();
        rsD = 5'd3; rtD = 5'd5;
        @(negedge clk);
        $display("[tb] load-use rtE=5 rtD=5 stall=%b flush=%b", stallV, flushV);
        checks++; if (stallV !== S_FD || flushV !== S_E) begin errors++; $display("FAIL lu_rt: got %b/%b want %b/%b", stallV, flushV, S_FD, S_E); end
        step();
        rtE = 5'd0; rsD = 5'd0; rtD = 5'd0;
        @(negedge clk);
        $display("[tb] load-use rtE=0 stall=%b flush=%b", stallV, flushV);
        checks++; if (stallV !== S_NONE || flushV !== S_NONE) begin errors++; $display("FAIL lu_r0: got %b/%b want 00000/00000", stallV, flushV); end
        step();
        mem_read_enE = 1'b0; rtE = 5'd5; rsD = 5'd5;
        @(negedge clk);
        checks++; if (stallV !== S_NONE || flushV !== S_NONE) begin errors++; $display("FAIL lu_noload: got %b/%b want 00000/00000", stallV, flushV); end
        step();
        idle();
    endtask

    task automatic test_exception();
        idle();
        exceptM = 1'b1;
        @(negedge clk);
        $display("[tb] except no-stall stall=%b flush=%b", stallV, flushV);
        checks++; if (stallV !== S_NONE || flushV !== S_ALL) begin errors++; $display("FAIL exc_plain: got %b/%b want 00000/11111", stallV, flushV); end
        step();
        exceptM = 1'b0;
        @(negedge clk);
        checks++; if (flushV !== S_NONE) begin errors++; $display("FAIL exc_plain_after: got %b want 00000", flushV); end
        step();
        exceptM = 1'b1; d_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            $display("[tb] except hold %0d stall=%b flush=%b", k, stallV, flushV);
            checks++; if (stallV !== S_ALL || flushV !== S_NONE) begin errors++; $display("FAIL exc_hold %0d: got %b/%b want 11111/00000", k, stallV, flushV); end
            step();
            exceptM = 1'b0;
        end
        d_stall = 1'b0;
        @(negedge clk);
        $display("[tb] except release stall=%b flush=%b", stallV, flushV);
        checks++; if (stallV !== S_NONE || flushV !== S_ALL) begin errors++; $display("FAIL exc_release: got %b/%b want 00000/11111", stallV, flushV); end
        step();
        @(negedge clk);
        checks++; if (stallV !== S_NONE || flushV !== S_NONE) begin errors++; $display("FAIL exc_once: got %b/%b want 00000/00000", stallV, flushV); end
        step();
    endtask

    task automatic test_except_div();
        idle();
        div_startE = 1'b1;
        step();
        div_startE = 1'b0;
        repeat (23) step();
        exceptM = 1'b1;
        @(negedge clk);
        $display("[tb] except at div_cnt=10 stall=%b flush=%b busy=%b", stallV, flushV, div_busy);
        checks++; if (stallV !== S_NONE || flushV !== S_ALL) begin errors++; $display("FAIL excdiv_flush: got %b/%b want 00000/11111", stallV, flushV); end
        step();
        exceptM = 1'b0;
        @(negedge clk);
        checks++; if (div_busy !== 1'b0 || stallV !== S_NONE || flushV !== S_NONE) begin errors++; $display("FAIL excdiv_abort: busy=%b got %b/%b want 0 00000/00000", div_busy, stallV, flushV); end
        step();
    endtask

    task automatic test_mispredict();
        idle();
        mispredE = 1'b1; d_stall = 1'b1;
        @(negedge clk);
        $display("[tb] mispred+d_stall stall=%b flush=%b", stallV, flushV);
        checks++; if (flushV !== S_NONE || stallV !== S_ALL) begin errors++; $display("FAIL mp_stalled: got %b/%b want 11111/00000", stallV, flushV); end
        step();
        d_stall = 1'b0;
        @(negedge clk);
        $display("[tb] mispred alone stall=%b flush=%b", stallV, flushV);
        checks++; if (flushV !== S_D || stallV !== S_NONE) begin errors++; $display("FAIL mp_alone: got %b/%b want 00000/%b", stallV, flushV, S_D); end
        step();
        mispredE = 1'b0;
        @(negedge clk);
        checks++; if (flushV !== S_NONE) begin errors++; $display("FAIL mp_once: got %b want 00000", flushV); end
        step();
    endtask

    task automatic test_reset_mid();
        idle();
        div_startE = 1'b1;
        step();
        div_startE = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        @(negedge clk);
        $display("[tb] reset mid-divide stall=%b flush=%b", stallV, flushV);
        checks++; if (stallV !== S_NONE || flushV !== S_NONE) begin errors++; $display("FAIL rstdiv_out: got %b/%b want 00000/00000", stallV, flushV); end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (div_busy !== 1'b0 || stallV !== S_NONE) begin errors++; $display("FAIL rstdiv_after: busy=%b stall=%b want 0/00000", div_busy, stallV); end
        step();
        exceptM = 1'b1; d_stall = 1'b1;
        step();
        exceptM = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0; d_stall = 1'b0;
        @(negedge clk);
        $display("[tb] after reset mid-hold stall=%b flush=%b", stallV, flushV);
        checks++; if (stallV !== S_NONE || flushV !== S_NONE) begin errors++; $display("FAIL rsthold_after: got %b/%b want 00000/00000", stallV, flushV); end
        step();
    endtask

    task automatic test_perf();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        div_startE = 1'b1;
        step();
        div_startE = 1'b0;
        repeat (34) step();
        mem_read_enE = 1'b1; rtE = 5'd7; rsD = 5'd7;
        step();
        step();
        idle();
        @(negedge clk);
        $display("[tb] perf after divide+2 load-use stall_cnt=%0d", stall_cnt);
        checks++; if (stall_cnt !== EXP_PERF) begin errors++; $display("FAIL perf_count: got %0d want %0d", stall_cnt, EXP_PERF); end
        rst = 1'b1;
        step();
        @(negedge clk);
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL perf_reset: got %0d want 0", stall_cnt); end
        rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_divide();
        test_load_use();
        test_exception();
        test_except_div();
        test_mispredict();
        test_reset_mid();
        test_perf();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
